// File: rtl/uart_rx_16x.sv
// 16x oversampled 8N1 UART receiver with a valid/ready byte output.
// Start detection aligns the tick divider phase so every sample lands mid-bit.
`timescale 1ns/1ps
module uart_rx_16x #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic [15:0]          divisor,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [3:0] HALF_BIT = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] FULL_BIT = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [1:0]           state;
    logic                 rxd_meta;
    logic                 rxd_s;
    logic                 rxd_prev;
    logic [15:0]          tick_cnt;
    logic [15:0]          reload;
    logic                 tick;
    logic                 fall;
    logic [3:0]           sample_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;

    assign reload = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
    assign tick   = (tick_cnt == 16'd0);
    assign fall   = rxd_prev & ~rxd_s;
    assign busy   = (state != S_IDLE);

    // Line synchronizer; all stages reset to the idle (high) level.
    always_ff @(posedge refclk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end

    // Reload on start detection so the tick phase follows the falling edge.
    always_ff @(posedge refclk) begin
        if (rst) begin
            tick_cnt <= 16'd0;
        end else if (((state == S_IDLE) && fall) || tick) begin
            tick_cnt <= reload;
        end else begin
            tick_cnt <= tick_cnt - 16'd1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= S_IDLE;
            sample_cnt  <= 4'd0;
            bit_idx     <= 3'd0;
            shift_reg   <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        sample_cnt <= 4'd0;
                        bit_idx    <= 3'd0;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (sample_cnt == HALF_BIT) begin
                            sample_cnt <= 4'd0;
                            state      <= rxd_s ? S_IDLE : S_DATA;
                        end else begin
                            sample_cnt <= sample_cnt + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        sample_cnt <= sample_cnt + 4'd1;
                        if (sample_cnt == FULL_BIT) begin
                            shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
                            bit_idx   <= bit_idx + 3'd1;
                            if (bit_idx == LAST_BIT) begin
                                state <= S_STOP;
                            end
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        sample_cnt <= sample_cnt + 4'd1;
                        if (sample_cnt == FULL_BIT) begin
                            state <= S_IDLE;
                            // A byte accepted on this same edge frees the holding register.
                            if (!rx_valid || rx_ready) begin
                                rx_data     <= shift_reg;
                                framing_err <= ~rxd_s;
                                rx_valid    <= 1'b1;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed self-checking bench for uart_rx_16x: one task per scenario.
`timescale 1ns/1ps
module tb_uart_rx_16x;

    logic        refclk;
    logic        rst;
    logic [15:0] divisor;
    logic        rxd;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        framing_err;
    logic        overrun_err;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    logic [7:0] got_q[$];
    logic       got_fe_q[$];
    int         valid_cycles   = 0;
    int         overrun_pulses = 0;

    uart_rx_16x #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .refclk      (refclk),
        .rst         (rst),
        .divisor     (divisor),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Records every accepted byte and counts valid cycles / overrun pulses.
    always @(negedge refclk) begin
        if (rx_valid) valid_cycles++;
        if (overrun_err) overrun_pulses++;
        if (rx_valid && rx_ready) begin
            got_q.push_back(rx_data);
            got_fe_q.push_back(framing_err);
        end
    end

    task automatic send_frame(input logic [7:0] data, input real bit_ns, input logic stop_bit);
        rxd = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            #(bit_ns);
        end
        rxd = stop_bit;
        #(bit_ns);
        rxd = 1'b1;
    endtask

    task automatic consume();
        @(posedge refclk); #1 rx_ready = 1'b1;
        @(posedge refclk); #1 rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rxd = 1'b1; rx_ready = 1'b0; divisor = 16'd1;
        repeat (4) @(posedge refclk);
        #1 rst = 1'b0;
        @(negedge refclk);
        checks++; if (rx_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", rx_valid); end
        checks++; if (framing_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_ferr: got %b expected 0", framing_err); end
        checks++; if (overrun_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_ovr: got %b expected 0", overrun_err); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic_byte();
        int  n;
        bit  seen;
        divisor = 16'd1; rx_ready = 1'b0;
        repeat (5) @(posedge refclk);
        #1;
        n = 0; seen = 1'b0;
        fork
            send_frame(8'hA5, 160.0, 1'b1);
            begin
                while (!seen && n < 400) begin
                    @(posedge refclk); n++;
                    @(negedge refclk);
                    if (rx_valid) seen = 1'b1;
                end
            end
        join
        checks++; if (n !== 155) begin fails++; $display("[TB] FAIL basic_latency: got %0d edges expected 155", n); end
        checks++; if (rx_data !== 8'hA5) begin fails++; $display("[TB] FAIL basic_data: got %h expected a5", rx_data); end
        checks++; if (framing_err !== 1'b0) begin fails++; $display("[TB] FAIL basic_ferr: got %b expected 0", framing_err); end
        consume();
        @(negedge refclk);
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_handshake: got valid %b expected 0", rx_valid); end
    endtask

    task automatic test_back_to_back();
        int q0, ov0, vc0;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        divisor = 16'd12; rx_ready = 1'b1;
        repeat (20) @(posedge refclk);
        #1;
        q0 = got_q.size(); ov0 = overrun_pulses; vc0 = valid_cycles;
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1920.0, 1'b1);
        repeat (50) @(posedge refclk);
        @(negedge refclk);
        checks++; if (got_q.size() - q0 !== 3) begin fails++; $display("[TB] FAIL b2b_count: got %0d bytes expected 3", got_q.size() - q0); end
        if (got_q.size() - q0 >= 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (got_q[q0+i] !== exp_b[i]) begin fails++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, got_q[q0+i], exp_b[i]); end
                checks++; if (got_fe_q[q0+i] !== 1'b0) begin fails++; $display("[TB] FAIL b2b_ferr%0d: got %b expected 0", i, got_fe_q[q0+i]); end
            end
        end
        checks++; if (valid_cycles - vc0 !== 3) begin fails++; $display("[TB] FAIL b2b_pulses: got %0d valid cycles expected 3", valid_cycles - vc0); end
        checks++; if (overrun_pulses - ov0 !== 0) begin fails++; $display("[TB] FAIL b2b_overrun: got %0d expected 0", overrun_pulses - ov0); end
        rx_ready = 1'b0; divisor = 16'd1;
        repeat (20) @(posedge refclk);
    endtask

    task automatic test_overrun();
        int q0, ov0;
        divisor = 16'd1; rx_ready = 1'b0;
        ov0 = overrun_pulses;
        @(posedge refclk); #1;
        send_frame(8'h11, 160.0, 1'b1);
        @(posedge refclk); #1;
        send_frame(8'h22, 160.0, 1'b1);
        repeat (5) @(posedge refclk);
        @(negedge refclk);
        checks++; if (rx_data !== 8'h11) begin fails++; $display("[TB] FAIL ovr_keep_data: got %h expected 11", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin fails++; $display("[TB] FAIL ovr_valid: got %b expected 1", rx_valid); end
        checks++; if (overrun_pulses - ov0 !== 1) begin fails++; $display("[TB] FAIL ovr_pulse: got %0d pulses expected 1", overrun_pulses - ov0); end
        q0 = got_q.size();
        @(posedge refclk); #1;
        fork
            send_frame(8'h22, 160.0, 1'b1);
            begin
                repeat (154) @(posedge refclk);
                #1 rx_ready = 1'b1;
                @(posedge refclk);
                #1 rx_ready = 1'b0;
            end
        join
        @(negedge refclk);
        checks++; if (rx_data !== 8'h22) begin fails++; $display("[TB] FAIL ovr_same_edge_data: got %h expected 22", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin fails++; $display("[TB] FAIL ovr_same_edge_valid: got %b expected 1", rx_valid); end
        checks++; if (overrun_pulses - ov0 !== 1) begin fails++; $display("[TB] FAIL ovr_same_edge_pulse: got %0d pulses expected 1", overrun_pulses - ov0); end
        checks++; if (got_q.size() - q0 !== 1) begin fails++; $display("[TB] FAIL ovr_same_edge_xfer: got %0d transfers expected 1", got_q.size() - q0); end
        else begin
            checks++; if (got_q[q0] !== 8'h11) begin fails++; $display("[TB] FAIL ovr_xfer_data: got %h expected 11", got_q[q0]); end
        end
        consume();
        repeat (5) @(posedge refclk);
    endtask

    task automatic test_glitch_break();
        divisor = 16'd1; rx_ready = 1'b0;
        @(posedge refclk); #1 rxd = 1'b0;
        repeat (3) @(posedge refclk);
        @(negedge refclk);
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL glitch_busy_on: got %b expected 1", busy); end
        repeat (2) @(posedge refclk);
        #1 rxd = 1'b1;
        repeat (8) @(posedge refclk);
        @(negedge refclk);
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL glitch_busy_off: got %b expected 0", busy); end
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("[TB] FAIL glitch_valid: got %b expected 0", rx_valid); end
        repeat (10) @(posedge refclk);
        #1 rxd = 1'b0;
        repeat (200) @(posedge refclk);
        @(negedge refclk);
        checks++; if (rx_valid !== 1'b1) begin fails++; $display("[TB] FAIL break_valid: got %b expected 1", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin fails++; $display("[TB] FAIL break_data: got %h expected 00", rx_data); end
        checks++; if (framing_err !== 1'b1) begin fails++; $display("[TB] FAIL break_ferr: got %b expected 1", framing_err); end
        consume();
        repeat (200) @(posedge refclk);
        @(negedge refclk);
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("[TB] FAIL break_no_refire: got valid %b expected 0", rx_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL break_idle: got busy %b expected 0", busy); end
        #1 rxd = 1'b1;
        repeat (20) @(posedge refclk);
        #1 send_frame(8'h81, 160.0, 1'b1);
        repeat (5) @(posedge refclk);
        @(negedge refclk);
        checks++; if (rx_data !== 8'h81) begin fails++; $display("[TB] FAIL after_break_data: got %h expected 81", rx_data); end
        checks++; if (framing_err !== 1'b0) begin fails++; $display("[TB] FAIL after_break_ferr: got %b expected 0", framing_err); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h5A;
        rx_ready = 1'b0;
        @(posedge refclk); #1 rxd = 1'b0;
        #160;
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            #160;
        end
        rxd = d[4];
        #80;
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL midframe_busy: got %b expected 1", busy); end
        @(posedge refclk); #1 rst = 1'b1;
        @(posedge refclk); #1 rst = 1'b0; rxd = 1'b1;
        @(negedge refclk);
        checks++; if (rx_data !== 8'h00) begin fails++; $display("[TB] FAIL midrst_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_valid: got %b expected 0", rx_valid); end
        checks++; if (framing_err !== 1'b0) begin fails++; $display("[TB] FAIL midrst_ferr: got %b expected 0", framing_err); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        repeat (20) @(posedge refclk);
        #1 send_frame(8'hC3, 160.0, 1'b1);
        repeat (5) @(posedge refclk);
        @(negedge refclk);
        checks++; if (rx_valid !== 1'b1) begin fails++; $display("[TB] FAIL post_rst_valid: got %b expected 1", rx_valid); end
        checks++; if (rx_data !== 8'hC3) begin fails++; $display("[TB] FAIL post_rst_data: got %h expected c3", rx_data); end
        checks++; if (framing_err !== 1'b0) begin fails++; $display("[TB] FAIL post_rst_ferr: got %b expected 0", framing_err); end
        consume();
        repeat (5) @(posedge refclk);
    endtask

    task automatic test_baud_skew();
        logic [7:0] exp_b [256];
        int q0;
        divisor = 16'd1; rx_ready = 1'b1;
        for (int i = 0; i < 256; i++) exp_b[i] = 8'($urandom);
        @(posedge refclk); #1;
        q0 = got_q.size();
        // Alternate a sender 3.5% slow and 3.5% fast relative to 16 cycles/bit.
        for (int i = 0; i < 256; i++) begin
            send_frame(exp_b[i], (i % 2 == 0) ? 165.6 : 154.4, 1'b1);
            #30;
        end
        repeat (50) @(posedge refclk);
        @(negedge refclk);
        checks++; if (got_q.size() - q0 !== 256) begin fails++; $display("[TB] FAIL skew_count: got %0d bytes expected 256", got_q.size() - q0); end
        if (got_q.size() - q0 >= 256) begin
            for (int i = 0; i < 256; i++) begin
                checks++; if (got_q[q0+i] !== exp_b[i]) begin fails++; $display("[TB] FAIL skew_data%0d: got %h expected %h", i, got_q[q0+i], exp_b[i]); end
                checks++; if (got_fe_q[q0+i] !== 1'b0) begin fails++; $display("[TB] FAIL skew_ferr%0d: got %b expected 0", i, got_fe_q[q0+i]); end
            end
        end
        rx_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rxd = 1'b1; rx_ready = 1'b0; divisor = 16'd1;
        test_reset();
        test_basic_byte();
        test_back_to_back();
        test_overrun();
        test_glitch_break();
        test_reset_mid_frame();
        test_baud_skew();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_16x.md
# uart_rx_16x

Asynchronous serial receiver for the RS232 path, clocked by the 1.8432 MHz PLL output. 16x oversampled, 8N1, LSB first. Converts the `rxd` line into bytes on a valid/ready interface toward the host logic. With `divisor` = 1 it receives at 115200 baud; larger divisors give the standard 16550 rates.

## Interface

**Parameters**
- `DATA_BITS`, 8: payload bits per frame (5–8).
- `OVERSAMPLE`, 16: ticks per bit; fixed at 16 and not configured per instance.

**Ports** (clock and reset first)
- `refclk` in 1: single clock (1.8432 MHz PLL output). All logic is on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `divisor` in 16: refclk cycles per oversample tick. A value of 0 is treated as 1.
- `rxd` in 1: serial line, idle high, asynchronous to `refclk`.
- `rx_data` out DATA_BITS: received byte.
- `rx_valid` out 1: `rx_data` holds an unconsumed byte.
- `rx_ready` in 1: consumer accepts the byte.
- `framing_err` out 1: stop bit of the byte in `rx_data` sampled low. Updated together with `rx_data`.
- `overrun_err` out 1: one-cycle pulse when a byte is dropped.
- `busy` out 1: FSM is not in IDLE.

## Operation

- **Synchronizer:** `rxd` passes through a 2-flop synchronizer with both stages reset to 1. `rxd_s` is the output; one further register holds the previous value for edge detection.
- **Tick generator:** a 16-bit down-counter loads `max(divisor,1)-1` and emits `tick` on terminal count.
  - It is reloaded on start detection, so phase is aligned to the falling edge.
  - A change to `divisor` takes effect at the next reload.
- **Bit timing:** a 4-bit sample counter and a 3-bit bit index track position in the frame.
- **FSM states:**
  - IDLE: waits for a falling edge on `rxd_s` (previous value 1, current value 0). On the edge, clear the counters and go to START.
  - START: on the 8th tick, sample `rxd_s`.
    - 1: treat as a glitch and return to IDLE. No output.
    - 0: clear the sample counter and go to DATA.
  - DATA: every 16th tick, shift `rxd_s` into the shift register, LSB first. After DATA_BITS samples, go to STOP.
  - STOP: on the 16th tick, sample the stop bit, complete the byte (see below), and go to IDLE the same cycle. A new start bit can therefore be detected from mid-stop onward.
- **Byte completion:**
  - If `rx_valid`=0 or `rx_ready`=1 in that cycle: load `rx_data` with the shift register, set `framing_err` = !stop sample, and set `rx_valid`=1.
  - Otherwise: drop the new byte, keep `rx_data`, `framing_err` and `rx_valid` unchanged, and pulse `overrun_err` for one cycle.
- **Handshake:** a transfer occurs on any cycle with `rx_valid`=1 and `rx_ready`=1. `rx_valid` clears on the next cycle unless a new byte loads in that same cycle; in that case `rx_valid` stays 1 with the new data and no overrun is flagged.
- **Break** (line held low through the stop bit): deliver `rx_data`=0x00 with `framing_err`=1. No new frame starts until `rxd_s` returns high and falls again.
- **Reset values:** `rx_data`=0, `rx_valid`=0, `framing_err`=0, `overrun_err`=0, `busy`=0, FSM in IDLE, synchronizer =1. Reset mid-frame discards the partial byte.

## Timing

- Tick period is `max(divisor,1)` refclk cycles. Bit period is 16 ticks.
- Sample points, counted in ticks after start detection:
  - start bit: 8
  - data bit n: 8+16(n+1)
  - stop bit: 8+16(DATA_BITS+1) = 152 for 8 bits
- Latency, with divisor=1 and `rxd` falling before refclk edge 0: start is detected at edge 2, and `rx_valid` is high after edge 154.
- With the default 1.8432 MHz clock and `divisor`=1 the baud rate is exactly 115200, and the receiver tolerates ±4% sender baud mismatch.
- `overrun_err` is a pulse aligned to the stop-sample edge.
- `rx_valid` has no combinational path from `rx_ready`.

## Test plan

- **Basic byte:** divisor=1, send 0xA5 8N1 at 16 cycles/bit with `rx_ready`=0 → `rx_valid` rises about 154 cycles after the start edge, `rx_data`=0xA5, `framing_err`=0. Then pulse `rx_ready` → `rx_valid`=0 on the next cycle.
- **Back-to-back with divisor:** divisor=12 (9600 baud), send 0x00, 0xFF, 0x3C back-to-back with `rx_ready`=1 → three single-cycle `rx_valid` pulses carrying those values in order, and no errors.
- **Overrun:** hold `rx_ready`=0 and send 0x11 then 0x22 → `rx_data` stays 0x11, one `overrun_err` pulse at the second stop sample. With `rx_ready` high on that same edge instead → `rx_data`=0x22 and no overrun.
- **Glitch and break:** a 5-cycle low glitch (divisor=1) → no output and `busy` back to 0 within 10 cycles. Line held low for 200 cycles → `rx_data`=0x00, `framing_err`=1, and no second frame until the line goes high and falls again.
- **Reset mid-frame:** assert `rst` for 1 cycle at bit 4 of 0x5A → all outputs 0 and `busy`=0. The next 0xC3 is received correctly.
- **Baud skew:** sender at ±3.5% of 16 cycles/bit, 256 random bytes → all received correctly and no framing errors.
